rggen_axi4lite_responder: RTL and testbench
===========================================

Name: rggen_axi4lite_responder

Overview: AXI4-Lite slave-end responder. Accepts AW/W/AR from the upstream AXI4-Lite buffer stage, serializes one access at a time onto the native register bus, and returns B/R responses with the echoed ID. Sits between the AXI4-Lite buffering stage and the register block.

Parameters:
ID_WIDTH, 0, AXI ID width; 0 means no ID.
ADDRESS_WIDTH, 8, byte address width.
BUS_WIDTH, 32, data width; 32 or 64.
ACTUAL_ID_WIDTH, max(1,ID_WIDTH), physical ID port width.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_awvalid  in  1  AW valid
o_awready  out  1  AW ready
i_awid / i_arid  in  ACTUAL_ID_WIDTH  write / read ID
i_awaddr / i_araddr  in  ADDRESS_WIDTH  write / read address
i_wvalid  in  1  W valid
o_wready  out  1  W ready
i_wdata  in  BUS_WIDTH  write data
i_wstrb  in  BUS_WIDTH/8  byte strobes
o_bvalid  out  1  B valid
i_bready  in  1  B ready
o_bid / o_rid  out  ACTUAL_ID_WIDTH  echoed ID
o_bresp / o_rresp  out  2  response code
i_arvalid  in  1  AR valid
o_arready  out  1  AR ready
o_rvalid  out  1  R valid
i_rready  in  1  R ready
o_rdata  out  BUS_WIDTH  read data
o_bus_valid  out  1  native access request
o_bus_write  out  1  1=write, 0=read
o_bus_address  out  ADDRESS_WIDTH  word-aligned address (low log2(BUS_WIDTH/8) bits zero)
o_bus_write_data  out  BUS_WIDTH  write data
o_bus_strobe  out  BUS_WIDTH/8  write strobes; all-ones on read
i_bus_ready  in  1  access complete
i_bus_status  in  2  00 okay, 01 slave error, 1x decode error
i_bus_read_data  in  BUS_WIDTH  read data, valid with i_bus_ready

Behaviour:
- AxPROT is not ported; protection is not checked.
- Interface: reset i_rst_n, asynchronous, active-low; clock i_clk.
- FSM states IDLE, ACCESS, RESPONSE. Reset: IDLE, aw/w latch flags 0, all registered outputs 0. o_awready/o_wready/o_arready are combinational and may be 1 during reset.
- o_awready = IDLE & !aw_latched & !(i_arvalid & !aw_latched & !w_latched). o_wready uses the same rule with w_latched.
- o_arready = IDLE & !aw_latched & !w_latched.
- Arbitration: read wins only when no write half is latched. Once AW or W is latched, AR is blocked until the write completes.
- AW and W may handshake in any order or in the same cycle. Each handshake latches its payload and sets its flag.
- Write start: when both flags are set at a clock edge in IDLE, go to ACCESS and clear both flags.
- Read start: an AR handshake at edge N latches ID/address and enters ACCESS. o_bus_valid=1 from cycle N+1.
- ACCESS: o_bus_valid and the bus payload stay stable until i_bus_ready. On the i_bus_ready edge, go to RESPONSE.
  - Register resp = 00/10/11 for status 00/01/1x.
  - On a read, register o_rdata. On a read error, o_rdata = 0.
  - o_bus_valid drops in the next cycle.
- RESPONSE: o_bvalid (write) or o_rvalid (read) asserts and holds with stable ID/resp/data until i_bready/i_rready. Then return to IDLE. Readies reassert the following cycle.
- Minimum turnaround: AR at N, bus ready at N+1, rvalid at N+2, rready at N+2, arready at N+3.
- Response valids and o_bus_valid never assert while in IDLE.
- Asynchronous reset mid-access aborts the transaction: all valids go low immediately and latches clear. No response is issued for the aborted transaction.

Test Plan:
- AW+W in the same cycle, addr 0x14, wdata 0xDEADBEEF, wstrb 0xF, id 3 → next cycle o_bus_valid=1, o_bus_write=1, address 0x14. Bus ready with status 00 → bvalid with bid=3, bresp=00.
- W first with wstrb 0x3, AW three cycles later at addr 0x17 → o_bus_address=0x14, strobe 0x3. arready stays 0 from the W handshake until write completion.
- AR at addr 0x08, read data 0x12345678, status 00 → rvalid, rdata=0x12345678, rresp=00, rid echoed. Hold rready low for 4 cycles → outputs stable the whole time.
- AR and AW+W valid in the same cycle with nothing latched → read serviced first. The write is accepted only after the R handshake.
- Read with status 01, then read with status 10 → rresp=10 and rdata=0, then rresp=11.
- Reset asserted during ACCESS → o_bus_valid, bvalid and rvalid go 0 immediately. After release: IDLE, all readies 1, no stale response.

Source files
------------

// File: rtl/rggen_axi4lite_responder.sv
// rtl/rggen_axi4lite_responder.sv - AXI4-Lite slave responder serializing accesses onto the native register bus
module rggen_axi4lite_responder #(
    parameter int ID_WIDTH        = 0,
    parameter int ADDRESS_WIDTH   = 8,
    parameter int BUS_WIDTH       = 32,
    parameter int ACTUAL_ID_WIDTH = (ID_WIDTH > 0) ? ID_WIDTH : 1
)(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_awvalid,
    output logic                       o_awready,
    input  logic [ACTUAL_ID_WIDTH-1:0] i_awid,
    input  logic [ADDRESS_WIDTH-1:0]   i_awaddr,
    input  logic                       i_wvalid,
    output logic                       o_wready,
    input  logic [BUS_WIDTH-1:0]       i_wdata,
    input  logic [BUS_WIDTH/8-1:0]     i_wstrb,
    output logic                       o_bvalid,
    input  logic                       i_bready,
    output logic [ACTUAL_ID_WIDTH-1:0] o_bid,
    output logic [1:0]                 o_bresp,
    input  logic                       i_arvalid,
    output logic                       o_arready,
    input  logic [ACTUAL_ID_WIDTH-1:0] i_arid,
    input  logic [ADDRESS_WIDTH-1:0]   i_araddr,
    output logic                       o_rvalid,
    input  logic                       i_rready,
    output logic [ACTUAL_ID_WIDTH-1:0] o_rid,
    output logic [1:0]                 o_rresp,
    output logic [BUS_WIDTH-1:0]       o_rdata,
    output logic                       o_bus_valid,
    output logic                       o_bus_write,
    output logic [ADDRESS_WIDTH-1:0]   o_bus_address,
    output logic [BUS_WIDTH-1:0]       o_bus_write_data,
    output logic [BUS_WIDTH/8-1:0]     o_bus_strobe,
    input  logic                       i_bus_ready,
    input  logic [1:0]                 i_bus_status,
    input  logic [BUS_WIDTH-1:0]       i_bus_read_data
);
    localparam int STRB_WIDTH = BUS_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~ADDRESS_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        RESPONSE = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic                       r_aw_latched;
    logic                       r_w_latched;
    logic [ACTUAL_ID_WIDTH-1:0] r_awid;
    logic [ADDRESS_WIDTH-1:0]   r_awaddr;
    logic [BUS_WIDTH-1:0]       r_wdata;
    logic [STRB_WIDTH-1:0]      r_wstrb;
    logic                       r_bus_write;
    logic [ADDRESS_WIDTH-1:0]   r_bus_address;
    logic [BUS_WIDTH-1:0]       r_bus_write_data;
    logic [STRB_WIDTH-1:0]      r_bus_strobe;
    logic [ACTUAL_ID_WIDTH-1:0] r_id;
    logic [1:0]                 r_resp;
    logic [BUS_WIDTH-1:0]       r_rdata;

    logic w_idle;
    logic w_read_pending;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_write_start;
    logic w_bus_done;
    logic w_resp_done;

    assign w_idle         = (r_state == IDLE);
    // A pending read only takes priority while neither write half has been captured.
    assign w_read_pending = i_arvalid & !r_aw_latched & !r_w_latched;
    assign o_awready      = w_idle & !r_aw_latched & !w_read_pending;
    assign o_wready       = w_idle & !r_w_latched & !w_read_pending;
    assign o_arready      = w_idle & !r_aw_latched & !r_w_latched;

    assign w_aw_hs       = i_awvalid & o_awready;
    assign w_w_hs        = i_wvalid & o_wready;
    assign w_ar_hs       = i_arvalid & o_arready;
    assign w_write_start = w_idle & (r_aw_latched | w_aw_hs) & (r_w_latched | w_w_hs);
    assign w_bus_done    = (r_state == ACCESS) & i_bus_ready;
    assign w_resp_done   = (r_state == RESPONSE) & (r_bus_write ? i_bready : i_rready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (w_write_start || w_ar_hs) w_next_state = ACCESS;
            ACCESS:   if (w_bus_done) w_next_state = RESPONSE;
            RESPONSE: if (w_resp_done) w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_aw_latched <= 1'b0;
            r_w_latched  <= 1'b0;
            r_awid       <= '0;
            r_awaddr     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
        end else begin
            if (w_write_start) begin
                r_aw_latched <= 1'b0;
                r_w_latched  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_latched <= 1'b1;
                if (w_w_hs)  r_w_latched  <= 1'b1;
            end
            if (w_aw_hs) begin
                r_awid   <= i_awid;
                r_awaddr <= i_awaddr;
            end
            if (w_w_hs) begin
                r_wdata <= i_wdata;
                r_wstrb <= i_wstrb;
            end
        end
    end

    // The half that completes the pair is taken straight from the port, the other from its latch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bus_write      <= 1'b0;
            r_bus_address    <= '0;
            r_bus_write_data <= '0;
            r_bus_strobe     <= '0;
            r_id             <= '0;
            r_resp           <= 2'b00;
            r_rdata          <= '0;
        end else begin
            if (w_write_start) begin
                r_bus_write      <= 1'b1;
                r_bus_address    <= (r_aw_latched ? r_awaddr : i_awaddr) & ADDR_MASK;
                r_bus_write_data <= r_w_latched ? r_wdata : i_wdata;
                r_bus_strobe     <= r_w_latched ? r_wstrb : i_wstrb;
                r_id             <= r_aw_latched ? r_awid : i_awid;
            end else if (w_ar_hs) begin
                r_bus_write   <= 1'b0;
                r_bus_address <= i_araddr & ADDR_MASK;
                r_bus_strobe  <= '1;
                r_id          <= i_arid;
            end
            if (w_bus_done) begin
                r_resp <= i_bus_status[1] ? 2'b11 : (i_bus_status[0] ? 2'b10 : 2'b00);
                if (!r_bus_write) begin
                    r_rdata <= (i_bus_status == 2'b00) ? i_bus_read_data : '0;
                end
            end
        end
    end

    assign o_bus_valid      = (r_state == ACCESS);
    assign o_bus_write      = r_bus_write;
    assign o_bus_address    = r_bus_address;
    assign o_bus_write_data = r_bus_write_data;
    assign o_bus_strobe     = r_bus_strobe;
    assign o_bvalid         = (r_state == RESPONSE) & r_bus_write;
    assign o_rvalid         = (r_state == RESPONSE) & !r_bus_write;
    assign o_bid            = r_id;
    assign o_rid            = r_id;
    assign o_bresp          = r_resp;
    assign o_rresp          = r_resp;
    assign o_rdata          = r_rdata;
endmodule

// File: tb/tb_rggen_axi4lite_responder.sv
// tb/tb_rggen_axi4lite_responder.sv - directed self-checking bench for rggen_axi4lite_responder
module tb_rggen_axi4lite_responder;
    localparam int IDW = 4;
    localparam int AW  = 8;
    localparam int BW  = 32;

    logic           i_clk = 1'b0;
    logic           i_rst_n = 1'b0;
    logic           i_awvalid = 1'b0, i_wvalid = 1'b0, i_bready = 1'b0;
    logic           i_arvalid = 1'b0, i_rready = 1'b0;
    logic [IDW-1:0] i_awid = '0, i_arid = '0;
    logic [AW-1:0]  i_awaddr = '0, i_araddr = '0;
    logic [BW-1:0]  i_wdata = '0, i_bus_read_data = '0;
    logic [BW/8-1:0] i_wstrb = '0;
    logic           i_bus_ready = 1'b0;
    logic [1:0]     i_bus_status = 2'b00;
    logic           o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
    logic [IDW-1:0] o_bid, o_rid;
    logic [1:0]     o_bresp, o_rresp;
    logic [BW-1:0]  o_rdata, o_bus_write_data;
    logic           o_bus_valid, o_bus_write;
    logic [AW-1:0]  o_bus_address;
    logic [BW/8-1:0] o_bus_strobe;

    int n_cmp = 0;
    int n_err = 0;

    rggen_axi4lite_responder #(
        .ID_WIDTH(IDW), .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awid(i_awid), .i_awaddr(i_awaddr),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid), .o_bresp(o_bresp),
        .i_arvalid(i_arvalid), .o_arready(o_arready), .i_arid(i_arid), .i_araddr(i_araddr),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rid(o_rid), .o_rresp(o_rresp), .o_rdata(o_rdata),
        .o_bus_valid(o_bus_valid), .o_bus_write(o_bus_write), .o_bus_address(o_bus_address),
        .o_bus_write_data(o_bus_write_data), .o_bus_strobe(o_bus_strobe),
        .i_bus_ready(i_bus_ready), .i_bus_status(i_bus_status), .i_bus_read_data(i_bus_read_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge i_clk);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge i_clk);
        mid();
        check_val("rst_awready", o_awready, 1);
        check_val("rst_wready", o_wready, 1);
        check_val("rst_arready", o_arready, 1);
        check_val("rst_bus_valid", o_bus_valid, 0);
        check_val("rst_bvalid", o_bvalid, 0);
        check_val("rst_rvalid", o_rvalid, 0);
        step();
        i_rst_n = 1'b1;

        // AW+W in the same cycle
        step();
        i_awvalid = 1; i_wvalid = 1; i_awaddr = 8'h14; i_awid = 4'd3;
        i_wdata = 32'hDEADBEEF; i_wstrb = 4'hF;
        mid();
        check_val("t1_awready", o_awready, 1);
        check_val("t1_wready", o_wready, 1);
        step();
        i_awvalid = 0; i_wvalid = 0;
        mid();
        check_val("t1_bus_valid", o_bus_valid, 1);
        check_val("t1_bus_write", o_bus_write, 1);
        check_val("t1_bus_addr", o_bus_address, 8'h14);
        check_val("t1_bus_wdata", o_bus_write_data, 32'hDEADBEEF);
        check_val("t1_bus_strobe", o_bus_strobe, 4'hF);
        step();
        mid();
        check_val("t1_bus_hold_valid", o_bus_valid, 1);
        check_val("t1_bus_hold_addr", o_bus_address, 8'h14);
        i_bus_ready = 1; i_bus_status = 2'b00;
        step();
        i_bus_ready = 0;
        mid();
        check_val("t1_bus_valid_drop", o_bus_valid, 0);
        check_val("t1_bvalid", o_bvalid, 1);
        check_val("t1_bid", o_bid, 3);
        check_val("t1_bresp", o_bresp, 0);
        i_bready = 1;
        step();
        i_bready = 0;
        mid();
        check_val("t1_bvalid_done", o_bvalid, 0);

        // W first, AW three cycles later; a waiting AR is blocked meanwhile
        step();
        i_wvalid = 1; i_wdata = 32'hCAFEF00D; i_wstrb = 4'h3;
        mid();
        check_val("t2_wready", o_wready, 1);
        step();
        i_wvalid = 0; i_arvalid = 1; i_araddr = 8'h08; i_arid = 4'd9;
        mid();
        check_val("t2_arready_blk0", o_arready, 0);
        check_val("t2_no_bus", o_bus_valid, 0);
        step();
        mid();
        check_val("t2_arready_blk1", o_arready, 0);
        step();
        i_awvalid = 1; i_awaddr = 8'h17; i_awid = 4'd5;
        mid();
        check_val("t2_awready", o_awready, 1);
        check_val("t2_arready_blk2", o_arready, 0);
        step();
        i_awvalid = 0;
        mid();
        check_val("t2_bus_valid", o_bus_valid, 1);
        check_val("t2_bus_write", o_bus_write, 1);
        check_val("t2_bus_addr", o_bus_address, 8'h14);
        check_val("t2_bus_strobe", o_bus_strobe, 4'h3);
        check_val("t2_bus_wdata", o_bus_write_data, 32'hCAFEF00D);
        check_val("t2_arready_blk3", o_arready, 0);
        i_bus_ready = 1;
        step();
        i_bus_ready = 0;
        mid();
        check_val("t2_bvalid", o_bvalid, 1);
        check_val("t2_bid", o_bid, 5);
        check_val("t2_arready_blk4", o_arready, 0);
        i_bready = 1;
        step();
        i_bready = 0;
        mid();
        check_val("t2_arready_after", o_arready, 1);

        // read at 0x08 with rready held low
        step();
        i_arvalid = 0;
        mid();
        check_val("t3_bus_valid", o_bus_valid, 1);
        check_val("t3_bus_write", o_bus_write, 0);
        check_val("t3_bus_addr", o_bus_address, 8'h08);
        check_val("t3_bus_strobe", o_bus_strobe, 4'hF);
        i_bus_ready = 1; i_bus_status = 2'b00; i_bus_read_data = 32'h12345678;
        step();
        i_bus_ready = 0; i_bus_read_data = 32'h0;
        for (int k = 0; k < 4; k++) begin
            mid();
            check_val($sformatf("t3_rvalid_%0d", k), o_rvalid, 1);
            check_val($sformatf("t3_rdata_%0d", k), o_rdata, 32'h12345678);
            check_val($sformatf("t3_rresp_%0d", k), o_rresp, 0);
            check_val($sformatf("t3_rid_%0d", k), o_rid, 9);
            step();
        end
        i_rready = 1;
        step();
        i_rready = 0;
        mid();
        check_val("t3_rvalid_done", o_rvalid, 0);
        check_val("t3_arready", o_arready, 1);

        // AR competing with AW+W: read first
        step();
        i_arvalid = 1; i_araddr = 8'h0C; i_arid = 4'd2;
        i_awvalid = 1; i_wvalid = 1; i_awaddr = 8'h20; i_awid = 4'd6;
        i_wdata = 32'h11223344; i_wstrb = 4'hF;
        mid();
        check_val("t4_arready", o_arready, 1);
        check_val("t4_awready_blk", o_awready, 0);
        check_val("t4_wready_blk", o_wready, 0);
        step();
        i_arvalid = 0;
        mid();
        check_val("t4_rd_write", o_bus_write, 0);
        check_val("t4_rd_addr", o_bus_address, 8'h0C);
        check_val("t4_awready_acc", o_awready, 0);
        i_bus_ready = 1; i_bus_read_data = 32'hAAAA5555;
        step();
        i_bus_ready = 0;
        mid();
        check_val("t4_rvalid", o_rvalid, 1);
        check_val("t4_rdata", o_rdata, 32'hAAAA5555);
        check_val("t4_rid", o_rid, 2);
        check_val("t4_awready_resp", o_awready, 0);
        i_rready = 1;
        step();
        i_rready = 0;
        mid();
        check_val("t4_awready_idle", o_awready, 1);
        check_val("t4_wready_idle", o_wready, 1);
        step();
        i_awvalid = 0; i_wvalid = 0;
        mid();
        check_val("t4_wr_write", o_bus_write, 1);
        check_val("t4_wr_addr", o_bus_address, 8'h20);
        check_val("t4_wr_wdata", o_bus_write_data, 32'h11223344);
        i_bus_ready = 1;
        step();
        i_bus_ready = 0;
        mid();
        check_val("t4_bvalid", o_bvalid, 1);
        check_val("t4_bid", o_bid, 6);
        i_bready = 1;
        step();
        i_bready = 0;

        // error responses
        i_arvalid = 1; i_araddr = 8'h04; i_arid = 4'd1;
        step();
        i_arvalid = 0; i_bus_ready = 1; i_bus_status = 2'b01; i_bus_read_data = 32'hFFFFFFFF;
        step();
        i_bus_ready = 0;
        mid();
        check_val("t5_slverr_rvalid", o_rvalid, 1);
        check_val("t5_slverr_rresp", o_rresp, 2'b10);
        check_val("t5_slverr_rdata", o_rdata, 0);
        i_rready = 1;
        step();
        i_rready = 0;
        i_arvalid = 1; i_araddr = 8'h08;
        step();
        i_arvalid = 0; i_bus_ready = 1; i_bus_status = 2'b10; i_bus_read_data = 32'h00000055;
        step();
        i_bus_ready = 0; i_bus_status = 2'b00;
        mid();
        check_val("t5_decerr_rresp", o_rresp, 2'b11);
        check_val("t5_decerr_rdata", o_rdata, 0);
        i_rready = 1;
        step();
        i_rready = 0;

        // reset during ACCESS
        i_awvalid = 1; i_wvalid = 1; i_awaddr = 8'h30; i_awid = 4'd7;
        step();
        i_awvalid = 0; i_wvalid = 0;
        mid();
        check_val("t6_bus_valid_pre", o_bus_valid, 1);
        #2;
        i_rst_n = 0;
        #1;
        check_val("t6_bus_valid_rst", o_bus_valid, 0);
        check_val("t6_bvalid_rst", o_bvalid, 0);
        check_val("t6_rvalid_rst", o_rvalid, 0);
        step();
        step();
        i_rst_n = 1;
        i_bready = 1; i_rready = 1;
        mid();
        check_val("t6_awready", o_awready, 1);
        check_val("t6_wready", o_wready, 1);
        check_val("t6_arready", o_arready, 1);
        repeat (3) step();
        mid();
        check_val("t6_no_bvalid", o_bvalid, 0);
        check_val("t6_no_rvalid", o_rvalid, 0);
        check_val("t6_no_bus_valid", o_bus_valid, 0);
        i_bready = 0; i_rready = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
